clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable integer clock divider: the parametrised successor of the fixed mod-N divider. It generates a divided clock `clk_out` and a one-cycle period `tick` from `clk`. The divisor is any value from 2 to 2^WIDTH-1 and can be changed while running; changes take effect glitch-free at the next period boundary. Odd divisors are supported with a defined duty split. The block sits in the clock/enable generation layer and feeds downstream counters, baud generators and strobes as a clock-enable source.

## Interface
- `WIDTH`, default 8: width of divisor, counter and `div_in`/`div_cur`.
- `DEFAULT_DIV`, default 3: divisor loaded at reset; must be in the range 2..2^WIDTH-1.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable; low freezes the divider.
- `div_in` in WIDTH: requested divisor.
- `div_load` in 1: one-cycle request to capture `div_in`.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: high for one cycle in the last cycle of each output period, registered.
- `div_cur` out WIDTH: divisor currently in effect.
- `busy` out 1: a captured divisor is pending and not yet applied.
- `cfg_err` out 1: one-cycle pulse when a `div_load` is rejected.

## Operation
- **State**
  - `cnt` (WIDTH bits) runs 0..D-1, where D = `div_cur`.
  - `pend` (WIDTH bits) holds the next divisor; `busy` flags that it is valid.
  - L = floor(D/2).
- **Output decode**
  - `clk_out` = (`cnt` >= L): low for L cycles, then high for D-L cycles. D=3 gives low 1, high 2. D=4 gives 2/2.
  - `tick` = `en` & (`cnt` == D-1).
  - Both are flops computed from next-state, so they align with the current `cnt`.
- **Reset** (asynchronous): `cnt`=0, `div_cur`=DEFAULT_DIV, `pend`=0, `busy`=0, `clk_out`=0, `tick`=0, `cfg_err`=0.
- **RUN** (`en`=1)
  - Each cycle `cnt` increments.
  - When `cnt`==D-1: `cnt` goes to 0. If `busy` was already high before this cycle, `div_cur` takes `pend` and `busy` clears in the same edge.
- **HOLD** (`en`=0)
  - `cnt`, `clk_out` and `div_cur` hold. `tick`=0.
  - Exception: if `busy`=1 while `en`=0, the next edge applies `pend` to `div_cur`, clears `busy`, forces `cnt`=0 and forces `clk_out`=0.
- **Load handshake**
  - When `div_load`=1 and `div_in` >= 2: `pend` takes `div_in` and `busy` is set on the next edge.
  - A load arriving while `busy`=1 overwrites `pend` (last request wins); `busy` stays high.
  - A load in the same cycle as a boundary is not applied at that boundary. It waits for the following boundary.
  - When `div_load`=1 and `div_in` < 2 (0 or 1): nothing is captured, `pend` and `busy` are unchanged, and `cfg_err` pulses on the next cycle.
- **Width rule**: all compares are unsigned WIDTH-bit. No overflow is possible because `cnt` never exceeds D-1 <= 2^WIDTH-2.

## Timing
- Output period is exactly D `clk` cycles. `tick` rate is 1/D.
- `clk_out` rising edges occur when `cnt` changes from L-1 to L, so they are spaced D cycles apart.
- There is no runt pulse across a divisor change: the old period completes in full before the new D applies.
- Latency from `div_load` to `div_cur` changing:
  - `en`=1: at the end of the first boundary strictly after the capture edge, i.e. between 1 and D_old cycles after capture.
  - `en`=0: 2 edges (capture, then apply).
- First period after reset release with `en`=1: `clk_out` is low for L cycles, then high. The first `tick` occurs in cycle D-1.
- Reset asserted mid-period forces the reset values immediately (asynchronously), and discards any pending load.
- `cfg_err` and `tick` are single-cycle pulses. `busy` is level.

## Test plan
- **Default divide**: reset, `en`=1, 12 cycles. Required: `clk_out` pattern 0,1,1 repeating; `tick` at `cnt`=2 every 3 cycles; `div_cur`=3.
- **Even and max divide**:
  - Load 4 then 255 (WIDTH=8). Required: D=4 gives 0,0,1,1. D=255 gives 127 cycles low then 128 high, with `tick` every 255 cycles.
- **Glitch-free change**:
  - Running D=5, load 2 when `cnt`=1.
  - Required: `busy`=1 until the boundary; the D=5 period completes; the next pattern is 0,1 repeating; `busy` clears when `div_cur` becomes 2.
- **Back-to-back and boundary collision**:
  - Load 6, then load 7 one cycle later. Required: only 7 is applied.
  - Load exactly in a `cnt`==D-1 cycle. Required: applied one period later.
- **Invalid load and HOLD**:
  - Load 1. Required: `cfg_err` pulses for 1 cycle; `div_cur` and `busy` are unchanged.
  - Drop `en` mid-period. Required: `cnt` and `clk_out` freeze and `tick`=0.
  - Load 9 while `en`=0. Required: `div_cur`=9 two edges later, with `cnt`=0 and `clk_out`=0.
- **Async reset mid-operation**:
  - Assert `rst` between clock edges while `busy`=1 and `cnt`=3.
  - Required: all outputs go to their reset values without waiting for a clock edge; `div_cur`=DEFAULT_DIV after release.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider producing a divided clock,
// a per-period tick, and glitch-free divisor changes at period boundaries.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] pend_q;

  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] pend_n;
  logic             busy_n;
  logic             clk_out_n;
  logic             tick_n;
  logic             cfg_err_n;
  logic             last;
  logic             load_ok;

  // Next-state: advance/wrap the counter, apply a pending divisor at a
  // boundary (or immediately while held), and capture valid load requests.
  always_comb begin
    cnt_n     = cnt_q;
    div_n     = div_cur;
    pend_n    = pend_q;
    busy_n    = busy;
    cfg_err_n = 1'b0;
    last      = (cnt_q == (div_cur - ONE));
    load_ok   = div_load && (div_in >= DIV_MIN);

    if (en) begin
      if (last) begin
        cnt_n = '0;
        if (busy) begin
          div_n  = pend_q;
          busy_n = 1'b0;
        end
      end else begin
        cnt_n = cnt_q + ONE;
      end
    end else if (busy) begin
      cnt_n  = '0;
      div_n  = pend_q;
      busy_n = 1'b0;
    end

    // A load in the same cycle as an apply is captured for the next boundary.
    if (load_ok) begin
      pend_n = div_in;
      busy_n = 1'b1;
    end
    cfg_err_n = div_load && !load_ok;

    // Outputs decoded from next state so they align with the registered count.
    clk_out_n = (cnt_n >= (div_n >> 1));
    tick_n    = en && (cnt_n == (div_n - ONE));
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pend_q  <= '0;
      div_cur <= DIV_RST;
      busy    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      div_cur <= div_n;
      busy    <= busy_n;
      clk_out <= clk_out_n;
      tick    <= tick_n;
      cfg_err <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random
// loads/enables against a period-position reference model.
module tb_clk_div_prog;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_cur;
  logic             busy;
  logic             cfg_err;

  int total = 0;
  int bad   = 0;

  // reference model: position within the output period and divisor bookkeeping
  int m_pos, m_div, m_pend;
  bit m_busy, m_err, m_tick, m_clk;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur),
    .busy    (busy),
    .cfg_err (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_div = 3; m_pend = 0;
    m_busy = 0; m_err = 0; m_tick = 0; m_clk = 0;
  endtask

  // One clock of the specified behaviour: a period lasts D cycles, the
  // output is low for the first floor(D/2) of them, and a pending divisor
  // replaces D only once the current period has ended (or at once when held).
  task automatic model_step(input bit e, input bit ld, input int din);
    bit was_busy;
    was_busy = m_busy;
    if (e) begin
      m_pos = (m_pos + 1) % m_div;
      if (m_pos == 0 && was_busy) begin
        m_div = m_pend;
        m_busy = 0;
      end
    end else if (was_busy) begin
      m_div = m_pend;
      m_busy = 0;
      m_pos = 0;
    end
    m_err = 0;
    if (ld) begin
      if (din >= 2) begin
        m_pend = din;
        m_busy = 1;
      end else begin
        m_err = 1;
      end
    end
    m_clk  = (m_pos >= m_div / 2);
    m_tick = e && (m_pos == m_div - 1);
  endtask

  // Compare process: every cycle out of reset, outputs vs. model.
  always @(posedge clk) begin
    if (!rst) begin
      model_step(en, div_load, int'(div_in));
      #1;
      chk("clk_out", 32'(clk_out), 32'(m_clk));
      chk("tick",    32'(tick),    32'(m_tick));
      chk("div_cur", 32'(div_cur), 32'(m_div));
      chk("busy",    32'(busy),    32'(m_busy));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
    end
  end

  task automatic ld(input int d);
    div_in   = WIDTH'(d);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic wait_div(input int d, input int budget);
    int n;
    n = 0;
    while (int'(div_cur) != d && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_div_timeout", 32'(div_cur), 32'(d));
  endtask

  task automatic wait_pos(input int p, input int budget);
    int n;
    n = 0;
    while (m_pos != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos_timeout", 32'(m_pos), 32'(p));
  endtask

  initial begin
    bit pat3 [3];
    bit tk3  [3];
    bit pat4 [4];
    bit pat2 [4];
    int n;
    int r;
    pat3 = '{1'b1, 1'b1, 1'b0};
    tk3  = '{1'b0, 1'b1, 1'b0};
    pat4 = '{1'b0, 1'b0, 1'b1, 1'b1};
    pat2 = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_div_cur", 32'(div_cur), 32'd3);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // default divide by 3
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("d3_clk", 32'(clk_out), 32'(pat3[i % 3]));
      chk("d3_tick", 32'(tick), 32'(tk3[i % 3]));
    end

    // even divide by 4
    ld(4);
    wait_div(4, 20);
    for (int i = 0; i < 4; i++) begin
      chk("d4_clk", 32'(clk_out), 32'(pat4[i]));
      @(negedge clk);
    end

    // max divide by 255: 127 low, 128 high
    ld(255);
    wait_div(255, 20);
    n = 0;
    while (clk_out == 1'b0 && n < 300) begin @(negedge clk); n++; end
    chk("d255_low", 32'(n), 32'd127);
    n = 0;
    while (clk_out == 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("d255_high", 32'(n), 32'd128);

    // back-to-back loads: only the last one takes effect
    ld(5);
    wait_div(5, 300);
    wait_pos(0, 10);
    ld(6);
    ld(7);
    chk("b2b_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("b2b_div", 32'(div_cur), 32'd7);

    // load in the last cycle of a period waits a full period
    wait_pos(6, 10);
    ld(4);
    chk("coll_div_hold", 32'(div_cur), 32'd7);
    chk("coll_busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    chk("coll_div_late", 32'(div_cur), 32'd7);
    @(negedge clk);
    chk("coll_div_apply", 32'(div_cur), 32'd4);

    // glitch-free change 5 -> 2 requested mid-period
    ld(5);
    wait_div(5, 10);
    wait_pos(1, 10);
    ld(2);
    chk("gf_busy", 32'(busy), 32'd1);
    chk("gf_div_old", 32'(div_cur), 32'd5);
    wait_div(2, 10);
    chk("gf_busy_clr", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("d2_clk", 32'(clk_out), 32'(pat2[i]));
      @(negedge clk);
    end

    // invalid load
    ld(1);
    chk("inv_err", 32'(cfg_err), 32'd1);
    chk("inv_div", 32'(div_cur), 32'd2);
    chk("inv_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("inv_err_clr", 32'(cfg_err), 32'd0);

    // hold, then load while held
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_tick", 32'(tick), 32'd0);
    ld(9);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_div_old", 32'(div_cur), 32'd2);
    @(negedge clk);
    chk("hold_div_new", 32'(div_cur), 32'd9);
    chk("hold_clk_low", 32'(clk_out), 32'd0);
    chk("hold_busy_clr", 32'(busy), 32'd0);

    // asynchronous reset mid-period with a load pending
    en = 1'b1;
    wait_pos(2, 20);
    ld(4);
    chk("ar_busy_pre", 32'(busy), 32'd1);
    chk("ar_pos_pre", 32'(m_pos), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar_clk_out", 32'(clk_out), 32'd0);
    chk("ar_tick",    32'(tick),    32'd0);
    chk("ar_div_cur", 32'(div_cur), 32'd3);
    chk("ar_busy",    32'(busy),    32'd0);
    chk("ar_cfg_err", 32'(cfg_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_div_after", 32'(div_cur), 32'd3);

    // randomized enables and loads
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 19));
      if (r < 2)       div_in = WIDTH'(r);
      else if (r == 19) div_in = WIDTH'($urandom_range(2, 255));
      else             div_in = WIDTH'(r - 4 < 2 ? 2 : r - 4);
      @(negedge clk);
    end
    div_load = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
